// File: rtl/dbg_spi_sched.sv
// dbg_spi_sched: shared debug SPI lane for N_CH 32-bit probe channels.
// Round-robin arbitration among pending probe words; each word is shipped
// as a 40-bit mode-0 frame {4'hA, 1'b0, id[2:0], data[31:0]}, MSB first.
// A one-cycle step pulse is emitted once every pending word has been sent.
// Optional macro DBG_SPI_CRC_EN appends a CRC-8 (poly 0x07) -> 48-bit frame.
module dbg_spi_sched #(
  parameter int N_CH = 3,
  parameter int DIV  = 100,
  parameter int GAP  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    req_valid,
  input  logic [32*N_CH-1:0] req_data,
  output logic [N_CH-1:0]    req_ready,
  output logic               spi_sck,
  output logic               spi_cs,
  output logic               spi_mosi,
  output logic               busy,
  output logic               step
);

`ifdef DBG_SPI_CRC_EN
  localparam int FRAME_W = 48;
`else
  localparam int FRAME_W = 40;
`endif
  localparam int PTR_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_CYC = 2 * DIV * GAP;
  localparam int GCNT_W  = $clog2(GAP_CYC);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GCNT_W-1:0]  gcnt_q, gcnt_d;
  logic [5:0]         bit_q, bit_d;
  logic               sck_q, sck_d;
  logic               cs_q, cs_d;
  logic               mosi_q, mosi_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               sent_q, sent_d;
  logic [N_CH-1:0]    ready_q, ready_d;
  logic               step_q, step_d;
  // Remaining frame bits after the one currently on MOSI.
  logic [FRAME_W-2:0] shreg_q;

  logic               gnt_found;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cidx;
  logic [31:0]        gnt_word;
  logic [2:0]         gnt_id;
  logic [39:0]        frame_base;
  logic [FRAME_W-1:0] frame;
  logic               load, shift;

`ifdef DBG_SPI_CRC_EN
  function automatic logic [7:0] crc8(input logic [39:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction
`endif

  // Round-robin pick: first valid channel strictly after the last grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cidx      = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cidx = PTR_W'((int'(ptr_q) + k) % N_CH);
      if (!gnt_found && req_valid[cidx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cidx;
      end
    end
  end

  // Granted word and tagged frame image.
  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (PTR_W'(i) == gnt_idx) gnt_word = req_data[32*i +: 32];
    end
    gnt_id     = 3'(gnt_idx);
    frame_base = {4'hA, 1'b0, gnt_id, gnt_word};
`ifdef DBG_SPI_CRC_EN
    frame = {frame_base, crc8(frame_base)};
`else
    frame = frame_base;
`endif
  end

  // Next-state logic for the IDLE / SHIFT / GAP sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    ptr_d   = ptr_q;
    sent_d  = sent_q;
    ready_d = '0;
    step_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          load             = 1'b1;
          ready_d[gnt_idx] = 1'b1;
          ptr_d            = gnt_idx;
          cs_d             = 1'b0;
          sck_d            = 1'b0;
          mosi_d           = frame[FRAME_W-1];
          sent_d           = 1'b1;
          cnt_d            = '0;
          bit_d            = '0;
          state_d          = ST_SHIFT;
        end else if (sent_q) begin
          step_d = 1'b1;
          sent_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            // Falling edge: either advance MOSI or close the frame.
            if (bit_q == 6'(FRAME_W - 1)) begin
              cs_d    = 1'b1;
              mosi_d  = 1'b0;
              gcnt_d  = '0;
              state_d = ST_GAP;
            end else begin
              bit_d  = bit_q + 6'd1;
              shift  = 1'b1;
              mosi_d = shreg_q[FRAME_W-2];
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gcnt_q == GCNT_W'(GAP_CYC - 1)) state_d = ST_IDLE;
        else gcnt_d = gcnt_q + GCNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and line state; async reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      ptr_q   <= PTR_W'(N_CH - 1);
      sent_q  <= 1'b0;
      ready_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      ptr_q   <= ptr_d;
      sent_q  <= sent_d;
      ready_q <= ready_d;
      step_q  <= step_d;
    end
  end

  // Frame shift register: pure data, never needs reset.
  always_ff @(posedge clk) begin
    if (load)       shreg_q <= frame[FRAME_W-2:0];
    else if (shift) shreg_q <= {shreg_q[FRAME_W-3:0], 1'b0};
  end

  assign req_ready = ready_q;
  assign spi_sck   = sck_q;
  assign spi_cs    = cs_q;
  assign spi_mosi  = mosi_q;
  assign busy      = (state_q != ST_IDLE);
  assign step      = step_q;

endmodule

// File: tb/tb_dbg_spi_sched.sv
// tb_dbg_spi_sched: table-driven bench for dbg_spi_sched (DIV=2, GAP=2).
// Frames are decoded from the SPI lines and compared against a scoreboard
// queue filled when stimulus is applied. Honours DBG_SPI_CRC_EN.
module tb_dbg_spi_sched;
  localparam int N_CH = 3;
  localparam int DIV  = 2;
  localparam int GAP  = 2;
`ifdef DBG_SPI_CRC_EN
  localparam int FW = 48;
`else
  localparam int FW = 40;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N_CH-1:0]    req_valid = '0;
  logic [32*N_CH-1:0] req_data = '0;
  logic [N_CH-1:0]    req_ready;
  logic               spi_sck, spi_cs, spi_mosi, busy, step;

  always #5 clk = ~clk;

  dbg_spi_sched #(.N_CH(N_CH), .DIV(DIV), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .spi_sck(spi_sck), .spi_cs(spi_cs),
    .spi_mosi(spi_mosi), .busy(busy), .step(step)
  );

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] sb[$];
  int step_cnt = 0;
  int rdy_cnt[N_CH];
  logic [N_CH-1:0] rearm = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

`ifdef DBG_SPI_CRC_EN
  function automatic logic [7:0] crc_model(input logic [39:0] m);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 39; i >= 0; i--) r = {r[6:0], 1'b0} ^ ((r[7] ^ m[i]) ? 8'h07 : 8'h00);
    return r;
  endfunction
`endif

  function automatic logic [FW-1:0] mk_frame(input logic [39:0] f);
`ifdef DBG_SPI_CRC_EN
    return {f, crc_model(f)};
`else
    return f;
`endif
  endfunction

  // Line monitor: decodes frames, checks timing, counts ready/step pulses.
  logic [FW-1:0]   fr = '0;
  int              nbits = 0, mcyc = 0, t_fall = 0, gap_cnt = 0;
  bit              in_frame = 0, in_gap = 0, first_rise = 0;
  bit              bad_busy = 0, bad_mosi = 0, bad_sck = 0;
  logic            sck_prev = 1'b0, cs_prev = 1'b1, mosi_prev = 1'b0, step_prev = 1'b0;
  logic [N_CH-1:0] ready_prev = '0;

  always begin
    @(posedge clk);
    #2;
    mcyc++;
    if (!rst_n) begin
      nbits = 0; in_frame = 0; in_gap = 0; first_rise = 0;
      bad_busy = 0; bad_mosi = 0; bad_sck = 0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (req_ready[i]) begin
          rdy_cnt[i]++;
          chk("ready_pulse_width", 64'(ready_prev[i]), 64'd0);
          chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
        end
      end
      if (step) begin
        step_cnt++;
        chk("step_with_pending", 64'(req_valid), 64'd0);
        chk("step_pulse_width", 64'(step_prev), 64'd0);
      end
      if (cs_prev && !spi_cs) begin
        in_frame = 1; nbits = 0; fr = '0; t_fall = mcyc; first_rise = 1;
        bad_busy = 0; bad_mosi = 0;
      end
      if (!spi_cs) begin
        if (!busy) bad_busy = 1;
        if (spi_sck && !sck_prev) begin
          if (spi_mosi !== mosi_prev) bad_mosi = 1;
          if (first_rise) begin
            chk("first_sck_latency", 64'(mcyc - t_fall), 64'(DIV));
            first_rise = 0;
          end
          fr = {fr[FW-2:0], spi_mosi};
          nbits++;
        end
      end
      if (spi_cs && spi_sck) bad_sck = 1;
      if (!cs_prev && spi_cs && in_frame) begin
        in_frame = 0;
        chk("frame_rising_edges", 64'(nbits), 64'(FW));
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected: got %0h, expected no frame", fr);
        end else begin
          chk("frame_data", 64'(fr), 64'(sb.pop_front()));
        end
        chk("busy_during_frame", 64'(bad_busy), 64'd0);
        chk("mosi_stable_on_rise", 64'(bad_mosi), 64'd0);
        chk("sck_low_while_cs_high", 64'(bad_sck), 64'd0);
        bad_sck = 0;
        in_gap = 1; gap_cnt = 0;
      end
      if (in_gap) begin
        if (busy) gap_cnt++;
        else begin
          chk("gap_length", 64'(gap_cnt), 64'(2*DIV*GAP));
          in_gap = 0;
        end
      end
    end
    sck_prev = spi_sck; cs_prev = spi_cs; mosi_prev = spi_mosi;
    step_prev = step; ready_prev = req_ready;
  end

  // Producers drop valid once they see their ready, unless re-arming.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N_CH; i++)
      if (req_ready[i] && !rearm[i]) req_valid[i] = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int steps_exp);
    int n;
    n = 0;
    while (!(sb.size() == 0 && step_cnt >= steps_exp && !busy) && n < 4000) begin
      tick(); n++;
    end
    if (n >= 4000) begin
      checks++; errors++;
      $display("FAIL wait_timeout: got %0d frames outstanding, expected 0", sb.size());
    end
    repeat (20) tick();
    chk("step_count", 64'(step_cnt), 64'(steps_exp));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
  endtask

  typedef struct {
    bit          rst;
    logic [2:0]  valid;
    logic [31:0] d0, d1, d2;
    logic [39:0] e0, e1, e2;
    int          ne;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{0, 3'b001, 32'h12345678, 32'h0, 32'h0, 40'hA012345678, 40'h0, 40'h0, 1};
    vecs[1] = '{1, 3'b111, 32'h1, 32'h2, 32'h3, 40'hA000000001, 40'hA100000002, 40'hA200000003, 3};
    vecs[2] = '{0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'h0, 40'hA0FFFFFFFF, 40'h0, 40'h0, 1};
    vecs[3] = '{0, 3'b001, 32'h00000000, 32'h0, 32'h0, 40'hA000000000, 40'h0, 40'h0, 1};
    vecs[4] = '{0, 3'b101, 32'hCAFEF00D, 32'h0, 32'h0BADBEEF, 40'hA20BADBEEF, 40'hA0CAFEF00D, 40'h0, 2};
    vecs[5] = '{0, 3'b110, 32'h0, 32'h80000001, 32'h7FFFFFFE, 40'hA180000001, 40'hA27FFFFFFE, 40'h0, 2};
    vecs[6] = '{0, 3'b011, 32'h55555555, 32'hAAAAAAAA, 32'h0, 40'hA055555555, 40'hA1AAAAAAAA, 40'h0, 2};
    vecs[7] = '{0, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 40'hA1DEADBEEF, 40'h0, 40'h0, 1};
    for (int i = 0; i < N_CH; i++) rdy_cnt[i] = 0;

    // Reset state, then idle without requests: no step.
    tick(); tick();
    chk("reset_outputs", 64'({spi_cs, spi_sck, spi_mosi, busy, step, req_ready}), 64'(8'b1000_0000));
    rst_n = 1'b1;
    repeat (30) tick();
    chk("idle_no_step", 64'(step_cnt), 64'd0);
    chk("idle_lines", 64'({spi_cs, spi_sck, busy}), 64'(3'b100));

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].rst) apply_reset();
      step_cnt = 0;
      for (int i = 0; i < N_CH; i++) rdy_cnt[i] = 0;
      req_data = {vecs[v].d2, vecs[v].d1, vecs[v].d0};
      if (vecs[v].ne >= 1) sb.push_back(mk_frame(vecs[v].e0));
      if (vecs[v].ne >= 2) sb.push_back(mk_frame(vecs[v].e1));
      if (vecs[v].ne >= 3) sb.push_back(mk_frame(vecs[v].e2));
      req_valid = vecs[v].valid;
      wait_done(1);
      for (int i = 0; i < N_CH; i++)
        chk($sformatf("vec%0d_ready_ch%0d", v, i), 64'(rdy_cnt[i]), 64'(vecs[v].valid[i]));
    end

    // Ch1/ch2 held valid: grants alternate, no step while pending.
    apply_reset();
    step_cnt = 0;
    for (int i = 0; i < N_CH; i++) rdy_cnt[i] = 0;
    req_data = {32'h22222222, 32'h11111111, 32'h0};
    for (int k = 0; k < 2; k++) begin
      sb.push_back(mk_frame(40'hA111111111));
      sb.push_back(mk_frame(40'hA222222222));
    end
    rearm = 3'b110;
    req_valid = 3'b110;
    n = 0;
    while (sb.size() != 0 && n < 4000) begin tick(); n++; end
    chk("hold_frames_done", 64'(sb.size()), 64'd0);
    chk("hold_no_step", 64'(step_cnt), 64'd0);
    req_valid = '0;
    rearm = '0;
    wait_done(1);
    chk("hold_ready_ch1", 64'(rdy_cnt[1]), 64'd2);
    chk("hold_ready_ch2", 64'(rdy_cnt[2]), 64'd2);

    // Reset in the middle of a frame, then ch0 wins over ch2.
    req_data = {32'h3C3C3C3C, 32'h0, 32'h0F0F0F0F};
    sb.push_back(mk_frame(40'hA00F0F0F0F));
    req_valid = 3'b001;
    n = 0;
    while (!(in_frame && nbits == 20) && n < 4000) begin tick(); n++; end
    chk("midframe_reached", 64'(nbits), 64'd20);
    chk("midframe_sck_high", 64'(spi_sck), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_lines", 64'({spi_cs, spi_sck, spi_mosi, busy, step, req_ready}), 64'(8'b1000_0000));
    sb.delete();
    req_valid = 3'b101;
    repeat (3) tick();
    step_cnt = 0;
    for (int i = 0; i < N_CH; i++) rdy_cnt[i] = 0;
    sb.push_back(mk_frame(40'hA00F0F0F0F));
    sb.push_back(mk_frame(40'hA23C3C3C3C));
    rst_n = 1'b1;
    wait_done(1);
    chk("post_reset_ready_ch0", 64'(rdy_cnt[0]), 64'd1);
    chk("post_reset_ready_ch2", 64'(rdy_cnt[2]), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
